pixel_stream_tx: RTL and testbench



---
 rtl/pixel_stream_tx_if.sv | 10 +
 rtl/pixel_stream_tx.sv | 114 +++++++++++
 tb/tb_pixel_stream_tx.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_tx_if.sv
// Upstream word stream into pixel_stream_tx: 4 packed 24-bit pixels per word.
// A word transfers on a rising edge where s_valid && s_ready; the source may hold s_valid, data is sampled only on that edge.
interface pixel_stream_tx_if;
  logic [95:0] s_word;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_word, output s_valid, input s_ready);
  modport slave  (input s_word, input s_valid, output s_ready);
endinterface

// File: rtl/pixel_stream_tx.sv
// Video timing generator that pulls 4-pixel words and serialises them one pixel per PixelClk.
// Oldest pixel sits in s_word[95:72], so a captured word replays in its original order.
module pixel_stream_tx #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0,
  parameter logic [23:0] FILL     = 24'hFF00FF
) (
  input  logic               PixelClk,
  input  logic               aPixelClkLckd,
  pixel_stream_tx_if.slave   s_if,
  output logic [23:0]        pData,
  output logic               pVDE,
  output logic               pHSync,
  output logic               pVSync,
  output logic               frame_start,
  output logic               underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_HS0  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_HS1  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_VS0  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_VS1  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [71:0]   sh_q, sh_d;
  logic [23:0]   pdata_q, pdata_d;
  logic          vde_q, hs_q, vs_q, fs_q, und_q, und_d;

  logic active, phase0, hs_on, vs_on, xfer;

  assign active = (h_q < H_ACT) && (v_q < V_ACT);
  assign phase0 = (h_q[1:0] == 2'd0);
  assign hs_on  = (h_q >= H_HS0) && (h_q < H_HS1);
  assign vs_on  = (v_q >= V_VS0) && (v_q < V_VS1);

  // Reset gates ready so no word can be consumed while the counters are held.
  assign s_if.s_ready = active && phase0 && aPixelClkLckd;
  assign xfer         = s_if.s_valid && s_if.s_ready;

  always_comb begin
    h_d     = (h_q == H_LAST) ? '0 : h_q + HW'(1);
    v_d     = v_q;
    if (h_q == H_LAST) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
    end
    pdata_d = 24'h0;
    sh_d    = sh_q;
    und_d   = und_q;
    if (active) begin
      if (phase0) begin
        if (xfer) begin
          pdata_d = s_if.s_word[95:72];
          sh_d    = s_if.s_word[71:0];
        end else begin
          pdata_d = FILL;
          sh_d    = {FILL, FILL, FILL};
          und_d   = 1'b1;
        end
      end else begin
        pdata_d = sh_q[71:48];
        sh_d    = {sh_q[47:0], 24'h0};
      end
    end
  end

  always_ff @(posedge PixelClk or negedge aPixelClkLckd) begin
    if (!aPixelClkLckd) begin
      h_q     <= '0;
      v_q     <= '0;
      sh_q    <= '0;
      pdata_q <= 24'h0;
      vde_q   <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      fs_q    <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      sh_q    <= sh_d;
      pdata_q <= pdata_d;
      vde_q   <= active;
      hs_q    <= hs_on ? SYNC_POL : ~SYNC_POL;
      vs_q    <= vs_on ? SYNC_POL : ~SYNC_POL;
      fs_q    <= (h_q == '0) && (v_q == '0);
      und_q   <= und_d;
    end
  end

  assign pData       = pdata_q;
  assign pVDE        = vde_q;
  assign pHSync      = hs_q;
  assign pVSync      = vs_q;
  assign frame_start = fs_q;
  assign underflow   = und_q;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Bench for pixel_stream_tx on a tiny 12x5 raster: a timing model predicts syncs/ready,
// and expected pixels are queued when words are offered and popped as pixels appear.
module tb_pixel_stream_tx;

  localparam int H_ACTIVE = 8, H_FP = 1, H_SYNC = 2, H_BP = 1;
  localparam int V_ACTIVE = 2, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [23:0] FILL = 24'hFF00FF;
  localparam logic [95:0] WORD_A = 96'h111111_222222_333333_444444;
  localparam logic [95:0] WORD_B = 96'hA1A2A3_B1B2B3_C1C2C3_D1D2D3;

  logic        PixelClk = 1'b0;
  logic        aPixelClkLckd;
  logic [23:0] pData;
  logic        pVDE, pHSync, pVSync, frame_start, underflow;

  pixel_stream_tx_if s_if ();

  pixel_stream_tx #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(1'b0), .FILL(FILL)
  ) dut (
    .PixelClk(PixelClk),
    .aPixelClkLckd(aPixelClkLckd),
    .s_if(s_if),
    .pData(pData),
    .pVDE(pVDE),
    .pHSync(pHSync),
    .pVSync(pVSync),
    .frame_start(frame_start),
    .underflow(underflow)
  );

  // clock / reset
  always #5 PixelClk = ~PixelClk;

  // scoreboard and model state
  logic [23:0] exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   mh, mv;
  int   dut_xfers, ready_blank;
  logic exp_vde, exp_hs, exp_vs, exp_fs, exp_ready, exp_und, obs_ready;
  logic [23:0] exp_pix;

  task automatic model_reset();
    mh = 0;
    mv = 0;
    exp_und = 1'b0;
    exp_q.delete();
  endtask

  // driver: offers one cycle of stimulus, records expectations, returns at the next negedge
  task automatic drive_cycle(input logic v, input logic [95:0] w);
    logic pre_active;
    s_if.s_valid = v;
    s_if.s_word  = w;
    #1;
    obs_ready  = s_if.s_ready;
    pre_active = (mh < H_ACTIVE) && (mv < V_ACTIVE);
    exp_ready  = pre_active && ((mh % 4) == 0);
    if (v && obs_ready) dut_xfers++;
    if (obs_ready && !pre_active) ready_blank++;
    if (exp_ready) begin
      if (v) begin
        exp_q.push_back(w[95:72]);
        exp_q.push_back(w[71:48]);
        exp_q.push_back(w[47:24]);
        exp_q.push_back(w[23:0]);
      end else begin
        repeat (4) exp_q.push_back(FILL);
        exp_und = 1'b1;
      end
    end
    exp_vde = pre_active;
    exp_hs  = !((mh >= H_ACTIVE + H_FP) && (mh < H_ACTIVE + H_FP + H_SYNC));
    exp_vs  = !((mv >= V_ACTIVE + V_FP) && (mv < V_ACTIVE + V_FP + V_SYNC));
    exp_fs  = (mh == 0) && (mv == 0);
    @(posedge PixelClk);
    mh++;
    if (mh == H_TOTAL) begin
      mh = 0;
      mv++;
      if (mv == V_TOTAL) mv = 0;
    end
    exp_pix = 24'h0;
    if (exp_vde) exp_pix = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hXXXXXX;
    @(negedge PixelClk);
  endtask

  task automatic apply_reset();
    aPixelClkLckd = 1'b0;
    s_if.s_valid  = 1'b0;
    model_reset();
    @(negedge PixelClk);
    aPixelClkLckd = 1'b1;
  endtask

  task automatic test_reset();
    aPixelClkLckd = 1'b0;
    s_if.s_valid  = 1'b1;
    s_if.s_word   = WORD_A;
    repeat (3) @(negedge PixelClk);
    tests++; if (pData !== 24'h0) begin fails++; $display("FAIL reset_pdata got=%h want=0", pData); end
    tests++; if (pVDE !== 1'b0) begin fails++; $display("FAIL reset_vde got=%b want=0", pVDE); end
    tests++; if (pHSync !== 1'b1) begin fails++; $display("FAIL reset_hsync got=%b want=1", pHSync); end
    tests++; if (pVSync !== 1'b1) begin fails++; $display("FAIL reset_vsync got=%b want=1", pVSync); end
    tests++; if (s_if.s_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b want=0", s_if.s_ready); end
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL reset_underflow got=%b want=0", underflow); end
    tests++; if (frame_start !== 1'b0) begin fails++; $display("FAIL reset_fs got=%b want=0", frame_start); end
    model_reset();
    aPixelClkLckd = 1'b1;
  endtask

  task automatic test_stream();
    dut_xfers = 0;
    for (int i = 0; i < H_TOTAL; i++) begin
      drive_cycle(1'b1, WORD_A);
      tests++; if (obs_ready !== exp_ready) begin fails++; $display("FAIL stream_ready cyc=%0d got=%b want=%b", i, obs_ready, exp_ready); end
      tests++; if (pVDE !== exp_vde) begin fails++; $display("FAIL stream_vde cyc=%0d got=%b want=%b", i, pVDE, exp_vde); end
      tests++; if (frame_start !== exp_fs) begin fails++; $display("FAIL stream_fs cyc=%0d got=%b want=%b", i, frame_start, exp_fs); end
      tests++; if (pData !== exp_pix) begin fails++; $display("FAIL stream_pdata cyc=%0d got=%h want=%h", i, pData, exp_pix); end
    end
    tests++; if (dut_xfers !== 2) begin fails++; $display("FAIL stream_xfers got=%0d want=2", dut_xfers); end
  endtask

  task automatic test_underflow();
    apply_reset();
    for (int i = 0; i < 2 * H_TOTAL; i++) begin
      drive_cycle(i != 4, WORD_A);
      tests++; if (pData !== exp_pix) begin fails++; $display("FAIL uf_pdata cyc=%0d got=%h want=%h", i, pData, exp_pix); end
      tests++; if (underflow !== exp_und) begin fails++; $display("FAIL uf_flag cyc=%0d got=%b want=%b", i, underflow, exp_und); end
    end
    tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL uf_sticky got=%b want=1", underflow); end
  endtask

  task automatic test_frames();
    int hs_low, vs_low, fs_cnt, last_fs;
    apply_reset();
    dut_xfers = 0; ready_blank = 0;
    hs_low = 0; vs_low = 0; fs_cnt = 0; last_fs = -1;
    for (int c = 0; c < 2 * H_TOTAL * V_TOTAL; c++) begin
      drive_cycle(1'b1, {$urandom, $urandom, $urandom});
      tests++; if (pHSync !== exp_hs) begin fails++; $display("FAIL fr_hsync cyc=%0d got=%b want=%b", c, pHSync, exp_hs); end
      tests++; if (pVSync !== exp_vs) begin fails++; $display("FAIL fr_vsync cyc=%0d got=%b want=%b", c, pVSync, exp_vs); end
      tests++; if (pVDE !== exp_vde) begin fails++; $display("FAIL fr_vde cyc=%0d got=%b want=%b", c, pVDE, exp_vde); end
      tests++; if (obs_ready !== exp_ready) begin fails++; $display("FAIL fr_ready cyc=%0d got=%b want=%b", c, obs_ready, exp_ready); end
      tests++; if (pData !== exp_pix) begin fails++; $display("FAIL fr_pdata cyc=%0d got=%h want=%h", c, pData, exp_pix); end
      if (pHSync === 1'b0) hs_low++;
      if (pVSync === 1'b0) vs_low++;
      if (frame_start === 1'b1) begin
        fs_cnt++;
        if (last_fs >= 0) begin
          tests++; if (c - last_fs !== 60) begin fails++; $display("FAIL fr_fs_period got=%0d want=60", c - last_fs); end
        end
        last_fs = c;
      end
    end
    tests++; if (hs_low !== 20) begin fails++; $display("FAIL fr_hs_count got=%0d want=20", hs_low); end
    tests++; if (vs_low !== 24) begin fails++; $display("FAIL fr_vs_count got=%0d want=24", vs_low); end
    tests++; if (fs_cnt !== 2) begin fails++; $display("FAIL fr_fs_count got=%0d want=2", fs_cnt); end
    tests++; if (dut_xfers !== 8) begin fails++; $display("FAIL fr_xfers got=%0d want=8", dut_xfers); end
    tests++; if (ready_blank !== 0) begin fails++; $display("FAIL fr_ready_blank got=%0d want=0", ready_blank); end
  endtask

  task automatic test_reset_midline();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(i != 0, WORD_A);
      tests++; if (pData !== exp_pix) begin fails++; $display("FAIL mid_pdata cyc=%0d got=%h want=%h", i, pData, exp_pix); end
    end
    aPixelClkLckd = 1'b0;
    #1;
    tests++; if (pData !== 24'h0) begin fails++; $display("FAIL mid_rst_pdata got=%h want=0", pData); end
    tests++; if (pVDE !== 1'b0) begin fails++; $display("FAIL mid_rst_vde got=%b want=0", pVDE); end
    tests++; if (pHSync !== 1'b1) begin fails++; $display("FAIL mid_rst_hsync got=%b want=1", pHSync); end
    tests++; if (s_if.s_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_ready got=%b want=0", s_if.s_ready); end
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL mid_rst_underflow got=%b want=0", underflow); end
    model_reset();
    @(negedge PixelClk);
    aPixelClkLckd = 1'b1;
    drive_cycle(1'b1, WORD_B);
    tests++; if (frame_start !== 1'b1) begin fails++; $display("FAIL mid_fs got=%b want=1", frame_start); end
    tests++; if (pData !== 24'hA1A2A3) begin fails++; $display("FAIL mid_first_pix got=%h want=a1a2a3", pData); end
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL mid_underflow got=%b want=0", underflow); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, WORD_B);
      tests++; if (pData !== exp_pix) begin fails++; $display("FAIL mid_pix cyc=%0d got=%h want=%h", i, pData, exp_pix); end
    end
  endtask

  initial begin
    aPixelClkLckd = 1'b0;
    s_if.s_valid  = 1'b0;
    s_if.s_word   = '0;
    dut_xfers     = 0;
    ready_blank   = 0;
    model_reset();
    @(negedge PixelClk);
    test_reset();
    test_stream();
    test_underflow();
    test_frames();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
